// File: rtl/eth_host_sequencer_if.sv
// -----------------------------------------------------------------------------
// eth_host_sequencer_if
// Purpose : bundles the host command/response stream and the processor-top
//           Ethernet load/compute port driven by eth_host_sequencer.
// Signals : cmd_*        command stream (valid/ready)
//           rsp_*        one-cycle response pulse (no backpressure)
//           busy         sequencer not idle
//           *_eth        processor-top port (interrupt, instruction, operand,
//                        address, web/wep strobes, write/read data)
//           done_comp    computation-complete level from the processor top
// Modports: slave  - the sequencer's view (takes commands, drives the port)
//           master - the host/top view (issues commands, returns read data)
// -----------------------------------------------------------------------------
interface eth_host_sequencer_if #(
   parameter int DATA_W = 60,
   parameter int ADDR_W = 11
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [2:0]        cmd_proc;
   logic [3:0]        cmd_mem;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_data;
   logic [7:0]        cmd_instr;

   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic              busy;

   logic              interrupt_eth;
   logic [7:0]        instruction_eth;
   logic [7:0]        operand_eth;
   logic [ADDR_W-1:0] address_eth;
   logic              web_eth;
   logic              wep_eth;
   logic [DATA_W-1:0] dinb_eth;
   logic [DATA_W-1:0] doutb_eth;
   logic              done_comp;

   modport slave (
      input  cmd_valid, cmd_op, cmd_proc, cmd_mem, cmd_addr, cmd_data, cmd_instr,
      input  doutb_eth, done_comp,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
      output interrupt_eth, instruction_eth, operand_eth, address_eth,
      output web_eth, wep_eth, dinb_eth
   );

   modport master (
      output cmd_valid, cmd_op, cmd_proc, cmd_mem, cmd_addr, cmd_data, cmd_instr,
      output doutb_eth, done_comp,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
      input  interrupt_eth, instruction_eth, operand_eth, address_eth,
      input  web_eth, wep_eth, dinb_eth
   );
endinterface

// File: rtl/eth_host_sequencer.sv
// -----------------------------------------------------------------------------
// eth_host_sequencer
// Purpose : converts a valid/ready command stream into the exact port cycles
//           of the NN/CRT processor top's Ethernet load/compute port:
//           data-memory writes, program-memory writes, data reads and
//           compute-instruction issue with a wait for done_comp.
// Ports   : clk    system clock
//           reset  synchronous, active-high
//           bus    eth_host_sequencer_if.slave (command stream, response
//                  pulse, busy, and the processor-top port)
// Notes   : every port output is a register; a command accepted at a clock
//           edge loads its port values on that same edge.
// -----------------------------------------------------------------------------
module eth_host_sequencer #(
   parameter int DATA_W        = 60,
   parameter int ADDR_W        = 11,
   parameter int RD_INSTR      = 2,
   parameter int READ_LAT      = 2,
   parameter int SETTLE_CYCLES = 2,
   parameter int TIMEOUT       = 1048576
) (
   input logic                clk,
   input logic                reset,
   eth_host_sequencer_if.slave bus
);

   // One counter serves read latency, settle time and the done timeout.
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

   localparam logic [1:0] OP_WR_DATA = 2'd0;
   localparam logic [1:0] OP_WR_PROG = 2'd1;
   localparam logic [1:0] OP_RD_DATA = 2'd2;
   localparam logic [1:0] OP_START   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_SETTLE,
      S_ISSUE,
      S_WAIT_DONE
   } state_t;

   state_t            r_state,       w_state;
   logic [CNT_W-1:0]  r_cnt,         w_cnt;
   logic              r_done_prev,   w_done_prev;
   logic [7:0]        r_instr_lat,   w_instr_lat;
   logic              r_interrupt,   w_interrupt;
   logic [7:0]        r_instruction, w_instruction;
   logic [7:0]        r_operand,     w_operand;
   logic [ADDR_W-1:0] r_address,     w_address;
   logic              r_web,         w_web;
   logic              r_wep,         w_wep;
   logic [DATA_W-1:0] r_dinb,        w_dinb;
   logic              r_rsp_valid,   w_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data,    w_rsp_data;
   logic              r_rsp_err,     w_rsp_err;
   logic              w_accept;
   logic              w_done_rise;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_done_prev   <= 1'b0;
         r_instr_lat   <= '0;
         r_interrupt   <= 1'b0;
         r_instruction <= '0;
         r_operand     <= '0;
         r_address     <= '0;
         r_web         <= 1'b0;
         r_wep         <= 1'b0;
         r_dinb        <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= '0;
         r_rsp_err     <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_cnt         <= w_cnt;
         r_done_prev   <= w_done_prev;
         r_instr_lat   <= w_instr_lat;
         r_interrupt   <= w_interrupt;
         r_instruction <= w_instruction;
         r_operand     <= w_operand;
         r_address     <= w_address;
         r_web         <= w_web;
         r_wep         <= w_wep;
         r_dinb        <= w_dinb;
         r_rsp_valid   <= w_rsp_valid;
         r_rsp_data    <= w_rsp_data;
         r_rsp_err     <= w_rsp_err;
      end
   end

   always_comb begin
      w_state       = r_state;
      w_cnt         = r_cnt;
      w_done_prev   = r_done_prev;
      w_instr_lat   = r_instr_lat;
      w_interrupt   = r_interrupt;
      w_instruction = r_instruction;
      w_operand     = r_operand;
      w_address     = r_address;
      w_web         = 1'b0;
      w_wep         = 1'b0;
      w_dinb        = r_dinb;
      w_rsp_valid   = 1'b0;
      w_rsp_data    = r_rsp_data;
      w_rsp_err     = 1'b0;
      w_accept      = bus.cmd_valid && ((r_state == S_IDLE) || (r_state == S_WRITE));
      // r_done_prev was loaded at ISSUE, so a level already high there must fall first.
      w_done_rise   = bus.done_comp && !r_done_prev;

      case (r_state)
         S_IDLE, S_WRITE: begin
            if (w_accept) begin
               case (bus.cmd_op)
                  OP_WR_DATA: begin
                     w_state       = S_WRITE;
                     w_interrupt   = 1'b1;
                     w_instruction = 8'd1;
                     w_operand     = {bus.cmd_proc, 1'b0, bus.cmd_mem};
                     w_address     = bus.cmd_addr;
                     w_dinb        = bus.cmd_data;
                     w_web         = 1'b1;
                  end
                  OP_WR_PROG: begin
                     // Program words are 32 bits; instruction/operand are left as they were.
                     w_state     = S_WRITE;
                     w_interrupt = 1'b1;
                     w_address   = bus.cmd_addr;
                     w_dinb      = DATA_W'(bus.cmd_data[31:0]);
                     w_wep       = 1'b1;
                  end
                  OP_RD_DATA: begin
                     w_state       = S_READ;
                     w_interrupt   = 1'b1;
                     w_instruction = 8'(RD_INSTR);
                     w_operand     = {bus.cmd_proc, 1'b0, bus.cmd_mem};
                     w_address     = bus.cmd_addr;
                     w_cnt         = '0;
                  end
                  OP_START: begin
                     w_instr_lat   = bus.cmd_instr;
                     w_interrupt   = 1'b0;
                     w_cnt         = '0;
                     if (SETTLE_CYCLES == 0) begin
                        w_state       = S_ISSUE;
                        w_instruction = bus.cmd_instr;
                     end else begin
                        w_state       = S_SETTLE;
                        w_instruction = 8'd0;
                     end
                  end
                  default: w_state = S_IDLE;
               endcase
            end else begin
               w_state       = S_IDLE;
               w_interrupt   = 1'b0;
               w_instruction = 8'd0;
            end
         end

         S_READ: begin
            if (r_cnt == CNT_W'(READ_LAT - 1)) begin
               w_state       = S_IDLE;
               w_interrupt   = 1'b0;
               w_instruction = 8'd0;
               w_rsp_valid   = 1'b1;
               w_rsp_data    = bus.doutb_eth;
               w_rsp_err     = 1'b0;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end

         S_SETTLE: begin
            if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
               w_state       = S_ISSUE;
               w_instruction = r_instr_lat;
               w_cnt         = '0;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end

         S_ISSUE: begin
            w_state     = S_WAIT_DONE;
            w_done_prev = bus.done_comp;
            w_cnt       = r_cnt + CNT_W'(1);
         end

         S_WAIT_DONE: begin
            w_done_prev = bus.done_comp;
            // A done edge coinciding with the timeout is reported as success.
            if (w_done_rise) begin
               w_state       = S_IDLE;
               w_instruction = 8'd0;
               w_rsp_valid   = 1'b1;
               w_rsp_data    = '0;
               w_rsp_err     = 1'b0;
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_state       = S_IDLE;
               w_instruction = 8'd0;
               w_rsp_valid   = 1'b1;
               w_rsp_data    = '0;
               w_rsp_err     = 1'b1;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end

         default: w_state = S_IDLE;
      endcase
   end

   assign bus.cmd_ready       = (r_state == S_IDLE) || (r_state == S_WRITE);
   assign bus.busy            = (r_state != S_IDLE);
   assign bus.rsp_valid       = r_rsp_valid;
   assign bus.rsp_data        = r_rsp_data;
   assign bus.rsp_err         = r_rsp_err;
   assign bus.interrupt_eth   = r_interrupt;
   assign bus.instruction_eth = r_instruction;
   assign bus.operand_eth     = r_operand;
   assign bus.address_eth     = r_address;
   assign bus.web_eth         = r_web;
   assign bus.wep_eth         = r_wep;
   assign bus.dinb_eth        = r_dinb;

endmodule
